// File: rtl/mod_scale_up.sv
// rtl/mod_scale_up.sv - sequential modular up-scaler, C = a * 2^SHIFT mod q
// One conditional-subtract doubling per cycle, valid/ready handshake on both sides.
module mod_scale_up #(
  parameter int DATA_SIZE = 30,
  parameter int SHIFT     = 30,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] q,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] C
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] SHIFT_C = CNT_W'(SHIFT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] r_q, r_d;
  logic [DATA_SIZE-1:0] q_q, q_d;
  logic [DATA_SIZE-1:0] c_q, c_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [DATA_SIZE-1:0] a_red;
  logic [DATA_SIZE:0]   t;
  logic [DATA_SIZE:0]   q_ext;
  logic [DATA_SIZE-1:0] r_step;

  // a < 2q, so one subtract brings the operand into [0, q).
  assign a_red = (a >= q) ? a - q : a;

  // Doubling keeps the carry bit so the compare sees the full DATA_SIZE+1 bits.
  assign t      = {r_q, 1'b0};
  assign q_ext  = {1'b0, q_q};
  assign r_step = (t >= q_ext) ? DATA_SIZE'(t - q_ext) : t[DATA_SIZE-1:0];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d   = q;
          r_d   = a_red;
          cnt_d = SHIFT_C;
          if (SHIFT_C == '0) begin
            c_d     = a_red;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = r_step;
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == ONE_C) begin
          c_d     = r_step;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held off during reset so no operand is taken while the block is being cleared.
  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign C         = c_q;

endmodule

// File: tb/tb_mod_scale_up.sv
// tb/tb_mod_scale_up.sv - randomized self-checking bench for mod_scale_up
module tb_mod_scale_up;
  localparam int DW = 30;
  localparam int SH = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] q, a, C;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] q0, a0, c0;
  logic          in_valid0, in_ready0, out_valid0, out_ready0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mod_scale_up #(.DATA_SIZE(DW), .SHIFT(SH), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .q(q), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .out_valid(out_valid), .out_ready(out_ready), .C(C)
  );

  mod_scale_up #(.DATA_SIZE(DW), .SHIFT(0), .CNT_W(6)) dut0 (
    .clk(clk), .reset(reset), .q(q0), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .out_valid(out_valid0), .out_ready(out_ready0), .C(c0)
  );

  function automatic logic [63:0] golden(input logic [63:0] av, input logic [63:0] qv, input int sh);
    logic [127:0] p;
    p = {64'd0, av} << sh;
    return 64'(p % {64'd0, qv});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [DW-1:0] av, input logic [DW-1:0] qv, input int hold, input string tag);
    int            lat;
    int            waited;
    bit            ok;
    logic [DW-1:0] c_first;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    a = av; q = qv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = DW'($urandom);
    q = DW'($urandom);
    lat = 1;
    ok  = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    check({tag, " latency"}, ok ? 64'(lat) : 64'hffff, 64'(SH + 1));
    check({tag, " C"}, 64'(C), golden(64'(av), 64'(qv), SH));
    c_first = C;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold C"}, 64'(C), 64'(c_first));
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, " drained out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " drained in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic op0(input logic [DW-1:0] av, input logic [DW-1:0] qv, input string tag);
    @(negedge clk);
    check({tag, " in_ready"}, 64'(in_ready0), 64'd1);
    a0 = av; q0 = qv; in_valid0 = 1'b1;
    @(posedge clk);
    #1 in_valid0 = 1'b0;
    a0 = DW'($urandom);
    @(negedge clk);
    check({tag, " out_valid cycle1"}, 64'(out_valid0), 64'd1);
    check({tag, " C"}, 64'(c0), 64'(av) % 64'(qv));
    out_ready0 = 1'b1;
    @(posedge clk);
    #1 out_ready0 = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rq, ra;
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; q = '0;
    in_valid0 = 1'b0; out_ready0 = 1'b0; a0 = '0; q0 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset C", 64'(C), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post reset in_ready", 64'(in_ready), 64'd1);

    op(30'd1, 30'd12289, 0, "q12289 a1");
    check("known 2738", golden(64'd1, 64'd12289, SH), 64'd2738);
    op(30'd12288, 30'd12289, 0, "q12289 a12288");
    op(30'd0, 30'd12289, 0, "q12289 a0");
    op(30'd12289, 30'd12289, 0, "q12289 a=q");
    op(30'd5, 30'h3fffffff, 0, "qmax a5");
    op(30'h3ffffffe, 30'h3fffffff, 0, "qmax a=q-1");
    op(30'd777, 30'd12289, 10, "backpressure");

    // Abort in RUN cycle 12: no result, block back in IDLE next cycle.
    @(negedge clk);
    a = 30'd1; q = 30'd12289; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid reset in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort C", 64'(C), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    op(30'd1, 30'd12289, 0, "after abort");

    op0(30'd150, 30'd97, "shift0 q97 a150");
    for (int i = 0; i < 8; i++) begin
      rq = DW'($urandom) | 30'd1;
      if (rq < 30'd3) rq = 30'd3;
      ra = DW'(64'($urandom) % (64'(rq) * 2));
      op0(ra, rq, "shift0 rand");
    end

    for (int i = 0; i < 20; i++) begin
      rq = DW'($urandom) | 30'd1;
      if (rq < 30'd3) rq = 30'd3;
      ra = DW'(64'($urandom) % 64'(rq));
      op(ra, rq, (i % 5 == 0) ? 2 : 0, "random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
